// File: rtl/adsr_step_rom_arbiter.sv
// Purpose : round-robin arbiter sharing one registered-output step ROM among NUM_REQ voices.
// Latency : grant, rom_re and rom_addr are registered one edge after req is sampled; rsp_valid follows one edge later.
// Backpressure: none; req is a level held until granted, one grant per cycle, and a granted voice is masked while its gnt is high.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   req[NUM_REQ]        per-voice request level
//   req_addr            per-voice step index, slice i = [i*ADDR_W +: ADDR_W]
//   gnt[NUM_REQ]        one-hot, one-cycle grant pulse
//   rsp_valid[NUM_REQ]  one-hot, one-cycle data-valid pulse (one cycle after gnt)
//   rsp_data            ROM data, meaningful only while rsp_valid is non-zero
//   rom_re, rom_addr    ROM read enable / address (registered)
//   rom_data            ROM registered data output (one-cycle read latency)
//
// Optional feature: define ADSR_ARB_LAST_HIT_EN to skip the ROM read when a grant
// targets the address of the most recent real read; the ROM output holds that data.

module adsr_step_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rom_re,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so ptr + offset can exceed NUM_REQ-1 before wrapping.
  localparam int CW    = PTR_W + 1;

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_vld;
  logic [CW-1:0]      cand;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [ADDR_W-1:0]  sel_addr;
  logic               issue_read;

  // A voice granted last edge still has req high this cycle; mask it so it is
  // not granted twice for one request.
  assign eligible = req & ~gnt;

  // Round-robin search starting at ptr. Walking offsets from high to low lets
  // the smallest offset (closest to ptr) win by being written last.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (eligible[cand[PTR_W-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Address mux and one-hot grant decode for the selected voice.
  always_comb begin
    sel_addr = '0;
    gnt_nxt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) begin
        sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
        gnt_nxt[i] = sel_vld;
      end
    end
  end

  assign ptr_nxt = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;

`ifdef ADSR_ARB_LAST_HIT_EN
  logic [ADDR_W-1:0] last_addr;
  logic              last_vld;

  // A repeat of the last real read needs no ROM access: the ROM's registered
  // output still holds that word when rsp_valid rises.
  assign issue_read = sel_vld && !(last_vld && (sel_addr == last_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      last_vld  <= 1'b0;
    end else if (issue_read) begin
      last_addr <= sel_addr;
      last_vld  <= 1'b1;
    end
  end
`else
  assign issue_read = sel_vld;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rom_re    <= 1'b0;
      rom_addr  <= '0;
    end else begin
      gnt       <= gnt_nxt;
      rsp_valid <= gnt;        // ROM data lands one edge after the read issues
      rom_re    <= issue_read;
      if (sel_vld) begin
        rom_addr <= sel_addr;  // holds its last value when idle
        ptr      <= ptr_nxt;
      end
    end
  end

  assign rsp_data = rom_data;

endmodule

// File: doc/adsr_step_rom_arbiter.md
ADSR_STEP_ROM_ARBITER -- requirements
Module: adsr_step_rom_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning number of voice requesters sharing one step ROM (range 2..16).
REQ-002 The block SHALL have parameter ADDR_W, default 7, meaning ROM address width.
REQ-003 The block SHALL have parameter DATA_W, default 19, meaning ROM data width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port req  input  NUM_REQ  per-voice request level, held until granted.
REQ-008 The block SHALL have port req_addr  input  NUM_REQ*ADDR_W  per-voice step index, slice i = bits [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port gnt  output  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-010 The block SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle data-valid pulse.
REQ-011 The block SHALL have port rsp_data  output  DATA_W  step size, meaningful only while any rsp_valid bit is high.
REQ-012 The block SHALL have ports rom_re  output  1, rom_addr  output  ADDR_W, and rom_data  input  DATA_W, connected to the ROM's read enable, address, and registered data output (one-cycle read latency).

Function
REQ-013 Each cycle, the block SHALL select one requester from eligible = req & ~gnt using round-robin arbitration.
REQ-014 The round-robin search SHALL start at pointer ptr; after granting index i, ptr SHALL become (i+1) mod NUM_REQ; ptr SHALL be unchanged when nothing is granted.
REQ-015 When a requester is selected at edge E0, gnt[i], rom_re=1 and rom_addr=req_addr slice i SHALL be registered at E0 and high for exactly one cycle.
REQ-016 At edge E1 (one cycle after E0), rsp_valid[i] SHALL be registered high for one cycle, with rsp_data = rom_data passed through combinationally.
REQ-017 Grant-to-data latency SHALL be one cycle, and total latency from req sampled to rsp_valid SHALL be two edges.
REQ-018 Throughput SHALL be one grant per cycle, with back-to-back grants to different requesters allowed and in-flight responses pipelined.
REQ-019 A requester whose gnt is high SHALL be masked for that cycle, so a requester that holds req one cycle too long is not double-granted.
REQ-020 A requester that keeps req high after the masked cycle SHALL be treated as a new request.
REQ-021 When eligible is all zero, gnt SHALL be 0 and rom_re SHALL be 0, and rom_addr SHALL hold its last value.
REQ-022 A requester's req_addr SHALL be sampled only in the cycle it is selected, and later changes SHALL NOT affect an issued read.
REQ-023 At most one gnt bit and one rsp_valid bit SHALL be high in any cycle.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously clear gnt, rsp_valid, rom_re, rom_addr, the last-address state, and set ptr=0.
REQ-025 A reset asserted mid-operation SHALL drop in-flight grants and responses with no rsp_valid for them after release.
REQ-026 The first arbitration after reset release SHALL give requester 0 highest priority.

Configuration
REQ-027 When ADSR_ARB_LAST_HIT_EN is defined, the block SHALL hold last_addr and last_vld (last_vld set by any issued read).
REQ-028 With ADSR_ARB_LAST_HIT_EN defined, a grant whose address equals last_addr while last_vld=1 SHALL keep rom_re=0, relying on the ROM output hold.
REQ-029 With ADSR_ARB_LAST_HIT_EN defined, gnt, rsp_valid and rsp_data timing SHALL be identical to a real read.
REQ-030 Without ADSR_ARB_LAST_HIT_EN, every grant SHALL assert rom_re and no last-address logic SHALL be present.

Verification
REQ-031 The bench SHALL cover: reset, then req=4'b0001 with addr0=7'h05 -> gnt=0001 next cycle, rom_re=1, rom_addr=05; rsp_valid=0001 with rsp_data=ROM[05] one cycle later.
REQ-032 The bench SHALL cover: req=4'b1111 held continuously -> grants 0,1,2,3,0 in consecutive cycles, with no requester granted twice in a row.
REQ-033 The bench SHALL cover: after a grant to 2, req=4'b0101 -> next grant to 0 (ptr=3 wraps to 0), then to 2.
REQ-034 The bench SHALL cover: requester 1 keeps req high for one cycle after gnt[1] -> no gnt in that cycle, single rsp_valid[1].
REQ-035 The bench SHALL cover: rst_n pulsed low while rsp_valid is pending -> all outputs 0 immediately, no rsp_valid after release, and first grant goes to 0.
REQ-036 The bench SHALL cover: with ADSR_ARB_LAST_HIT_EN, voices 0 and 1 both request 7'h10 -> second grant has rom_re=0, and both rsp_data equal ROM[10].
